// File: rtl/midi_voice_allocator.sv
// MIDI voice allocator. It parses Note On, Note Off and CC 123 from the UART byte stream.
// It assigns notes to NUM_VOICES voices: a retrigger is tried first, then a free voice, then the LRU steal.
module midi_voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CHANNEL    = 0
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    input  logic                      i_RX_DV,
    input  logic [7:0]                i_RX_Byte,
    output logic [7*NUM_VOICES-1:0]   o_Voice_Note,
    output logic [7*NUM_VOICES-1:0]   o_Voice_Vel,
    output logic [NUM_VOICES-1:0]     o_Voice_Gate,
    output logic [NUM_VOICES-1:0]     o_Voice_Trig
);

    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned NW = 7;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA1, ST_DATA2, ST_EXEC} state_t;
    typedef enum logic [1:0] {MSG_NONE, MSG_OFF, MSG_ON, MSG_CC} msg_t;

    state_t          state;
    msg_t            rs_msg;
    logic [NW-1:0]   d1_q;
    logic [NW-1:0]   d2_q;
    logic [NW-1:0]   note_q [NUM_VOICES];
    logic [NW-1:0]   vel_q  [NUM_VOICES];
    logic [IW-1:0]   rank_q [NUM_VOICES];

    msg_t            status_msg;
    logic            chan_ok;
    logic            hit;
    logic            free;
    logic [IW-1:0]   hit_idx;
    logic [IW-1:0]   free_idx;
    logic [IW-1:0]   old_idx;
    logic [IW-1:0]   sel_idx;
    logic            note_on;

    // Classify the incoming status byte by message type and channel
    always_comb begin
        status_msg = MSG_NONE;
        case (i_RX_Byte[7:4])
            4'h8:    status_msg = MSG_OFF;
            4'h9:    status_msg = MSG_ON;
            4'hB:    status_msg = MSG_CC;
            default: status_msg = MSG_NONE;
        endcase
        chan_ok = (CHANNEL >= 16) || (i_RX_Byte[3:0] == 4'(CHANNEL));
    end

    // Voice choice: a gated voice already holding d1, then the lowest free voice, then the oldest voice
    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        old_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate_hit(v)) begin
                hit     = 1'b1;
                hit_idx = IW'(v);
            end
            if (!o_Voice_Gate[v]) begin
                free     = 1'b1;
                free_idx = IW'(v);
            end
            if (rank_q[v] == IW'(NUM_VOICES - 1)) old_idx = IW'(v);
        end
        sel_idx = hit ? hit_idx : (free ? free_idx : old_idx);
        note_on = (rs_msg == MSG_ON) && (d2_q != '0);
    end

    function automatic logic gate_hit(input int v);
        return o_Voice_Gate[v] && (note_q[v] == d1_q);
    endfunction

    // Flatten the per-voice registers onto the output buses
    always_comb begin
        o_Voice_Note = '0;
        o_Voice_Vel  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            o_Voice_Note[NW*v +: NW] = note_q[v];
            o_Voice_Vel[NW*v +: NW]  = vel_q[v];
        end
    end

    // Parser FSM and voice state update
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= ST_IDLE;
            rs_msg       <= MSG_NONE;
            d1_q         <= '0;
            d2_q         <= '0;
            o_Voice_Gate <= '0;
            o_Voice_Trig <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                vel_q[v]  <= '0;
                rank_q[v] <= IW'(v);
            end
        end else begin
            o_Voice_Trig <= '0;
            if (state == ST_EXEC) begin
                if (note_on) begin
                    note_q[sel_idx]       <= d1_q;
                    vel_q[sel_idx]        <= d2_q;
                    o_Voice_Gate[sel_idx] <= 1'b1;
                    o_Voice_Trig[sel_idx] <= 1'b1;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IW'(v) == sel_idx)
                            rank_q[v] <= '0;
                        else if (rank_q[v] < rank_q[sel_idx])
                            rank_q[v] <= rank_q[v] + IW'(1);
                    end
                end else if (rs_msg == MSG_ON || rs_msg == MSG_OFF) begin
                    for (int v = 0; v < NUM_VOICES; v++)
                        if (gate_hit(v)) o_Voice_Gate[v] <= 1'b0;
                end else if (rs_msg == MSG_CC && d1_q == NW'(123)) begin
                    o_Voice_Gate <= '0;
                end
                state <= (rs_msg != MSG_NONE) ? ST_DATA1 : ST_IDLE;
            end else if (i_RX_DV) begin
                if (i_RX_Byte[7]) begin
                    // Realtime bytes (F8-FF) leave the parser untouched
                    if (i_RX_Byte < 8'hF8) begin
                        if (i_RX_Byte < 8'hF0 && status_msg != MSG_NONE && chan_ok) begin
                            rs_msg <= status_msg;
                            state  <= ST_DATA1;
                        end else begin
                            rs_msg <= MSG_NONE;
                            state  <= ST_IDLE;
                        end
                    end
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rs_msg != MSG_NONE) begin
                                d1_q  <= i_RX_Byte[6:0];
                                state <= ST_DATA2;
                            end
                        end
                        ST_DATA1: begin
                            d1_q  <= i_RX_Byte[6:0];
                            state <= ST_DATA2;
                        end
                        ST_DATA2: begin
                            d2_q  <= i_RX_Byte[6:0];
                            state <= ST_EXEC;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed testbench for midi_voice_allocator (NUM_VOICES=4, CHANNEL=0).
module tb_midi_voice_allocator;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic        i_RX_DV = 1'b0;
    logic [7:0]  i_RX_Byte = 8'h00;
    logic [27:0] o_Voice_Note;
    logic [27:0] o_Voice_Vel;
    logic [3:0]  o_Voice_Gate;
    logic [3:0]  o_Voice_Trig;

    int n_checks = 0;
    int n_pass   = 0;

    midi_voice_allocator #(.NUM_VOICES(4), .CHANNEL(0)) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_RX_DV      (i_RX_DV),
        .i_RX_Byte    (i_RX_Byte),
        .o_Voice_Note (o_Voice_Note),
        .o_Voice_Vel  (o_Voice_Vel),
        .o_Voice_Gate (o_Voice_Gate),
        .o_Voice_Trig (o_Voice_Trig)
    );

    // 100 MHz clock
    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] note_of(input int v);
        return 32'(o_Voice_Note[7*v +: 7]);
    endfunction

    function automatic logic [31:0] vel_of(input int v);
        return 32'(o_Voice_Vel[7*v +: 7]);
    endfunction

    // One DV pulse, then one quiet cycle; returns 1 ns after the edge that follows the capture edge
    task automatic send(input logic [7:0] b);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(posedge i_Clk); #1;
        i_RX_DV   = 1'b0;
        @(posedge i_Clk); #1;
    endtask

    task automatic tick();
        @(posedge i_Clk); #1;
    endtask

    task automatic do_reset();
        i_Rst_L = 1'b0;
        #4;
        i_Rst_L = 1'b1;
        tick();
    endtask

    task automatic four_notes();
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h3D); send(8'h64);
        send(8'h3E); send(8'h64);
        send(8'h3F); send(8'h64);
    endtask

    initial begin
        #12;
        chk("rst_gate", 32'(o_Voice_Gate), 32'h0);
        chk("rst_trig", 32'(o_Voice_Trig), 32'h0);
        chk("rst_note", 32'(o_Voice_Note[27:0]), 32'h0);
        i_Rst_L = 1'b1;
        tick();

        // Basic note on
        send(8'h90); send(8'h3C); send(8'h64);
        chk("t1_note0", note_of(0), 32'h3C);
        chk("t1_vel0",  vel_of(0),  32'h64);
        chk("t1_gate",  32'(o_Voice_Gate), 32'h1);
        chk("t1_trig",  32'(o_Voice_Trig), 32'h1);
        tick();
        chk("t1_trig_off", 32'(o_Voice_Trig), 32'h0);

        // Running status, note off via vel 0, explicit 0x80 and unmatched off
        send(8'h40); send(8'h50);
        chk("t2_note1", note_of(1), 32'h40);
        chk("t2_vel1",  vel_of(1),  32'h50);
        chk("t2_trig",  32'(o_Voice_Trig), 32'h2);
        send(8'h3C); send(8'h00);
        chk("t2_gate_off", 32'(o_Voice_Gate), 32'h2);
        chk("t2_note0_kept", note_of(0), 32'h3C);
        chk("t2_off_notrig", 32'(o_Voice_Trig), 32'h0);
        send(8'h80); send(8'h55); send(8'h00);
        chk("t2_unmatched", 32'(o_Voice_Gate), 32'h2);
        send(8'h40); send(8'h00);
        chk("t2_80_off", 32'(o_Voice_Gate), 32'h0);

        // Steal oldest, then retrigger
        do_reset();
        four_notes();
        chk("t3_four_gates", 32'(o_Voice_Gate), 32'hF);
        send(8'h40); send(8'h64);
        chk("t3_steal_trig", 32'(o_Voice_Trig), 32'h1);
        chk("t3_steal_note", note_of(0), 32'h40);
        chk("t3_steal_gate", 32'(o_Voice_Gate), 32'hF);
        send(8'h3D); send(8'h70);
        chk("t3_retrig", 32'(o_Voice_Trig), 32'h2);
        chk("t3_retrig_vel", vel_of(1), 32'h70);
        chk("t3_note0_kept", note_of(0), 32'h40);
        // After the steal and retrigger, voice2 (3E) is the oldest
        send(8'h41); send(8'h64);
        chk("t3_steal2", 32'(o_Voice_Trig), 32'h4);
        chk("t3_steal2_note", note_of(2), 32'h41);

        // Channel filter, realtime pass-through, foreign status abort
        do_reset();
        send(8'h91); send(8'h3C); send(8'h64);
        chk("t4_chan_gate", 32'(o_Voice_Gate), 32'h0);
        chk("t4_chan_trig", 32'(o_Voice_Trig), 32'h0);
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        chk("t4_rt_gate", 32'(o_Voice_Gate), 32'h1);
        chk("t4_rt_trig", 32'(o_Voice_Trig), 32'h1);
        do_reset();
        send(8'h90); send(8'h3C); send(8'hA0); send(8'h64);
        chk("t4_abort_gate", 32'(o_Voice_Gate), 32'h0);
        send(8'h3E); send(8'h64);
        chk("t4_abort_drop", 32'(o_Voice_Gate), 32'h0);

        // Other CC ignored, CC 123 clears all gates
        do_reset();
        four_notes();
        send(8'hB0); send(8'h07); send(8'h00);
        chk("t5_cc7", 32'(o_Voice_Gate), 32'hF);
        send(8'h7B); send(8'h00);
        chk("t5_ano_gate", 32'(o_Voice_Gate), 32'h0);
        chk("t5_ano_trig", 32'(o_Voice_Trig), 32'h0);
        chk("t5_note3", note_of(3), 32'h3F);
        chk("t5_vel2",  vel_of(2),  32'h64);

        // Async reset mid-message
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3C);
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk("t6_rst_gate", 32'(o_Voice_Gate), 32'h0);
        chk("t6_rst_note", 32'(o_Voice_Note[27:0]), 32'h0);
        chk("t6_rst_vel",  32'(o_Voice_Vel[27:0]), 32'h0);
        #1;
        i_Rst_L = 1'b1;
        tick();
        send(8'h64);
        chk("t6_drop", 32'(o_Voice_Gate), 32'h0);
        send(8'h90); send(8'h3C); send(8'h64);
        chk("t6_assign_trig", 32'(o_Voice_Trig), 32'h1);
        chk("t6_assign_note", note_of(0), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
